l2_writeback_buffer: RTL and testbench
======================================

Name: l2_writeback_buffer

Overview:
- Sits between the L2 cache and physical memory.
- Absorbs dirty-line evictions from the L2 into a small FIFO so the L2's following miss fill reaches memory without waiting on the writeback.
- Forwards L2 reads that hit a buffered line and drains the FIFO to memory when the L2 is idle.
- Upstream and downstream use the same blocking read/write/resp handshake on 128-bit lines.

Parameters:
- DEPTH, 2, number of buffered cachelines (power of two, 2..8)
- AW, 16, address width (lc3b_word)
- LW, 128, line width (lc3b_cacheline)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- l2_read  in  1  L2 line read request; held until l2_resp
- l2_write  in  1  L2 line writeback request; held until l2_resp
- l2_address  in  AW  line address; bits [3:0] ignored
- l2_wdata  in  LW  writeback line
- l2_rdata  out  LW  read data; valid when l2_resp=1
- l2_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_address  out  AW  memory line address, bits [3:0]=0
- pmem_wdata  out  LW  memory write data
- pmem_rdata  in  LW  memory read data
- pmem_resp  in  1  memory completion pulse
- buf_count  out  log2(DEPTH)+1  occupied entries
- buf_empty  out  1  buf_count==0

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; head, tail and count cleared; entry valid bits cleared.
  - l2_resp, pmem_read, pmem_write = 0; l2_rdata, pmem_address, pmem_wdata = 0.
- Storage: DEPTH entries of {tag[AW-1:4], line}, circular head/tail pointers that wrap modulo DEPTH.
- Address match compares [AW-1:4] only.
- State machine (Moore outputs):
  - IDLE:
    - l2_read and l2_write both high is illegal (assertion); l2_read wins.
    - l2_read with a buffered match: latch the youngest matching line into l2_rdata -> RESP.
    - l2_read with no match -> MEM_READ.
    - l2_write with count<DEPTH: enqueue at tail -> RESP.
    - l2_write with count==DEPTH -> DRAIN. The write stays pending and is accepted after the pop.
    - No request and count>0 -> DRAIN.
  - MEM_READ:
    - pmem_read=1, pmem_address={l2_address[AW-1:4],4'h0}.
    - On pmem_resp, latch pmem_rdata into l2_rdata -> RESP.
  - DRAIN:
    - pmem_write=1, pmem_address={head tag,4'h0}, pmem_wdata=head line.
    - On pmem_resp, pop head -> IDLE.
    - Not abortable; new L2 requests wait.
  - RESP:
    - l2_resp=1 for exactly one cycle; requests are not sampled -> IDLE.
- Latency:
  - Buffered write and read hit: l2_resp in the 2nd cycle after the request is first seen in IDLE.
  - Read miss: l2_resp in the cycle after pmem_resp.
- Priority: pending L2 requests beat draining. Draining happens only when IDLE sees no request, or the buffer is full and a write is pending.
- Ordering: drain in FIFO order. Memory never sees a read of an address while an older write to that address is still buffered, because the read is forwarded instead.
- Enqueue and pop never occur in the same cycle.
- count never exceeds DEPTH and never underflows.
- pmem_read and pmem_write are never high together.

Optional Feature:
- L2_WB_COALESCE_EN defined:
  - An l2_write whose address matches a buffered entry overwrites that entry's line in place. No enqueue, count unchanged.
  - Accepted even when the buffer is full; response timing is the same as an enqueue.
- Undefined:
  - Every write enqueues, so duplicates can coexist.
  - Reads forward the youngest match; the drain writes both copies in order.

Test Plan:
- Reset mid-DRAIN (pmem_write=1) -> next cycle pmem_write=0, buf_count=0, buf_empty=1, state IDLE.
- l2_write 0x1230 data A, then l2_read 0x1238 -> l2_resp, l2_rdata=A, pmem_read never asserted.
- DEPTH=2: writes to 0x1000 and 0x2000, then write 0x3000 -> pmem_write 0x1000 first. After pmem_resp, 0x3000 is accepted; buf_count=2, l2_resp once.
- l2_read 0x4440 miss with memory responding after 5 cycles -> pmem_read held 5 cycles, l2_rdata=pmem_rdata, l2_resp one cycle later.
- Writes 0x5000 B then 0x5000 C, then idle:
  - Coalesce on: buf_count=1, one memory write of C.
  - Coalesce off: buf_count=2, memory writes B then C.
  - Either way, a read of 0x5000 before drain returns C.
- Idle with 2 entries, l2_read arriving during DRAIN -> the read is serviced after the drain's pmem_resp, and the second entry drains afterwards.

Source files
------------

// File: rtl/l2_writeback_buffer_if.sv
// L2 <-> writeback buffer <-> physical memory line handshake bundle.
// slave: buffer side; master: L2 cache plus memory side.
interface l2_writeback_buffer_if #(
  parameter int AW = 16,
  parameter int LW = 128
) ();
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  modport slave (
    input  l2_read, l2_write, l2_address, l2_wdata,
    input  pmem_rdata, pmem_resp,
    output l2_rdata, l2_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output l2_read, l2_write, l2_address, l2_wdata,
    output pmem_rdata, pmem_resp,
    input  l2_rdata, l2_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l2_writeback_buffer.sv
// Dirty-line writeback FIFO between L2 and memory, with read forwarding.
// Define L2_WB_COALESCE_EN to merge writes that hit a buffered line.
module l2_writeback_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 16,
  parameter int LW    = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  l2_writeback_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = AW - 4;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, MEM_READ, DRAIN, RESP
  } state_e;

  state_e        state_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [DEPTH-1:0] vld_q;
  logic [TW-1:0] tag_q  [DEPTH];
  logic [LW-1:0] line_q [DEPTH];

  logic          l2_resp_q;
  logic [LW-1:0] l2_rdata_q;
  logic          pmem_read_q;
  logic          pmem_write_q;
  logic [AW-1:0] pmem_address_q;
  logic [LW-1:0] pmem_wdata_q;

  logic [TW-1:0] tag_in;
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] idx;
  logic          coal;

  assign tag_in = bus.l2_address[AW-1:4];

  // Walk oldest to youngest so the last match is the youngest copy.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (vld_q[idx] && tag_q[idx] == tag_in) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

`ifdef L2_WB_COALESCE_EN
  always_comb coal = hit;
`else
  always_comb coal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      vld_q          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
      l2_resp_q      <= 1'b0;
      l2_rdata_q     <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.l2_read) begin
            if (hit) begin
              l2_rdata_q <= line_q[hit_idx];
              l2_resp_q  <= 1'b1;
              state_q    <= RESP;
            end else begin
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {tag_in, 4'h0};
              state_q        <= MEM_READ;
            end
          end else if (bus.l2_write && coal) begin
            line_q[hit_idx] <= bus.l2_wdata;
            l2_resp_q       <= 1'b1;
            state_q         <= RESP;
          end else if (bus.l2_write && count_q != FULL) begin
            tag_q[tail_q]  <= tag_in;
            line_q[tail_q] <= bus.l2_wdata;
            vld_q[tail_q]  <= 1'b1;
            tail_q         <= tail_q + PW'(1);
            count_q        <= count_q + CW'(1);
            l2_resp_q      <= 1'b1;
            state_q        <= RESP;
          end else if (bus.l2_write || count_q != '0) begin
            // Full with a write pending, or idle: retire the head.
            pmem_write_q   <= 1'b1;
            pmem_address_q <= {tag_q[head_q], 4'h0};
            pmem_wdata_q   <= line_q[head_q];
            state_q        <= DRAIN;
          end
        end
        MEM_READ: begin
          if (bus.pmem_resp) begin
            pmem_read_q <= 1'b0;
            l2_rdata_q  <= bus.pmem_rdata;
            l2_resp_q   <= 1'b1;
            state_q     <= RESP;
          end
        end
        DRAIN: begin
          if (bus.pmem_resp) begin
            pmem_write_q  <= 1'b0;
            vld_q[head_q] <= 1'b0;
            head_q        <= head_q + PW'(1);
            count_q       <= count_q - CW'(1);
            state_q       <= IDLE;
          end
        end
        RESP: begin
          l2_resp_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.l2_resp      = l2_resp_q;
  assign bus.l2_rdata     = l2_rdata_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
  assign buf_count        = count_q;
  assign buf_empty        = (count_q == '0);

  a_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
    state_q == IDLE |-> !(bus.l2_read && bus.l2_write));
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= FULL);
  a_pmem_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(pmem_read_q && pmem_write_q));

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Directed bench for l2_writeback_buffer: vector table plus
// multi-cycle sequences against a latency-programmable memory model.
module tb_l2_writeback_buffer;

  localparam int DEPTH = 2;
  localparam int AW    = 16;
  localparam int LW    = 128;

  localparam logic [LW-1:0] DA = {4{32'hAAAA_0001}};
  localparam logic [LW-1:0] DB = {4{32'hBBBB_0002}};
  localparam logic [LW-1:0] DC = {4{32'hCCCC_0003}};
  localparam logic [LW-1:0] DX = {4{32'h1111_0004}};
  localparam logic [LW-1:0] DY = {4{32'h2222_0005}};
  localparam logic [LW-1:0] DZ = {4{32'h3333_0006}};
  localparam logic [LW-1:0] DE = {4{32'hEEEE_0007}};
  localparam logic [LW-1:0] DF = {4{32'hFFFF_0008}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [$clog2(DEPTH):0] buf_count;
  logic buf_empty;

  l2_writeback_buffer_if #(.AW(AW), .LW(LW)) bus ();

  l2_writeback_buffer #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .buf_count (buf_count),
    .buf_empty (buf_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mem_lat = 3;
  int rd_cycles = 0;
  int resp_cnt = 0;
  logic [AW-1:0] wa_q [$];
  logic [LW-1:0] wd_q [$];

  always @(negedge clk) if (bus.pmem_read) rd_cycles++;
  always @(negedge clk) if (bus.l2_resp) resp_cnt++;

  // Memory: answers in the mem_lat-th cycle of a request, data = address x8.
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write) begin
        for (int k = 1; k < mem_lat; k++) @(negedge clk);
        if (bus.pmem_read || bus.pmem_write) begin
          bus.pmem_rdata = {8{bus.pmem_address}};
          bus.pmem_resp  = 1'b1;
          if (bus.pmem_write) begin
            wa_q.push_back(bus.pmem_address);
            wd_q.push_back(bus.pmem_wdata);
          end
          @(posedge clk);
          #1 bus.pmem_resp = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called right after a negedge; returns at the negedge showing l2_resp.
  task automatic l2_req(input logic rd, input logic [AW-1:0] a,
                        input logic [LW-1:0] d,
                        output logic [LW-1:0] rdata, output int lat);
    bus.l2_read    = rd;
    bus.l2_write   = !rd;
    bus.l2_address = a;
    bus.l2_wdata   = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.l2_resp && lat < 200);
    rdata = bus.l2_rdata;
    bus.l2_read  = 1'b0;
    bus.l2_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (!buf_empty && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, LW'(buf_empty), LW'(1));
  endtask

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] exp_rdata;
    int            exp_cnt;
    int            exp_lat;
    int            exp_rdc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [LW-1:0] rdata;
    int lat, n, base, rdc0, rc0;

    bus.l2_read    = 1'b0;
    bus.l2_write   = 1'b0;
    bus.l2_address = '0;
    bus.l2_wdata   = '0;

    vecs[0] = '{1'b0, 16'h1230, DA, '0, 1, 1, 0};
    vecs[1] = '{1'b1, 16'h1238, '0, DA, 1, 1, 0};
    vecs[2] = '{1'b1, 16'h4440, '0, {8{16'h4440}}, 1, 4, 3};
    vecs[3] = '{1'b0, 16'h2000, DB, '0, 2, 1, 0};
    vecs[4] = '{1'b1, 16'h2004, '0, DB, 2, 1, 0};
    vecs[5] = '{1'b1, 16'h123F, '0, DA, 2, 1, 0};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_l2_resp", LW'(bus.l2_resp), '0);
    chk("rst_pmem_read", LW'(bus.pmem_read), '0);
    chk("rst_pmem_write", LW'(bus.pmem_write), '0);
    chk("rst_l2_rdata", bus.l2_rdata, '0);
    chk("rst_pmem_addr", LW'(bus.pmem_address), '0);
    chk("rst_pmem_wdata", bus.pmem_wdata, '0);
    chk("rst_count", LW'(buf_count), '0);
    chk("rst_empty", LW'(buf_empty), LW'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a drain is outstanding
    mem_lat = 20;
    l2_req(1'b0, 16'h0100, DA, rdata, lat);
    n = 0;
    while (!bus.pmem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("s1_drain_started", LW'(bus.pmem_write), LW'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("s1_pmem_write", LW'(bus.pmem_write), '0);
    chk("s1_count", LW'(buf_count), '0);
    chk("s1_empty", LW'(buf_empty), LW'(1));
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    // Vector table, issued back to back
    mem_lat = 3;
    do_reset();
    foreach (vecs[i]) begin
      rdc0 = rd_cycles;
      @(negedge clk);
      l2_req(vecs[i].rd, vecs[i].addr, vecs[i].wdata, rdata, lat);
      chk($sformatf("v%0d_lat", i), LW'(lat), LW'(vecs[i].exp_lat));
      chk($sformatf("v%0d_count", i), LW'(buf_count),
          LW'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_rdcyc", i), LW'(rd_cycles - rdc0),
          LW'(vecs[i].exp_rdc));
      if (vecs[i].rd)
        chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end

    // Full buffer: write waits for one drain
    do_reset();
    base = wa_q.size();
    @(negedge clk);
    l2_req(1'b0, 16'h1000, DX, rdata, lat);
    @(negedge clk);
    l2_req(1'b0, 16'h2000, DY, rdata, lat);
    @(negedge clk);
    rc0 = resp_cnt;
    l2_req(1'b0, 16'h3000, DZ, rdata, lat);
    chk("s2_lat", LW'(lat), LW'(5));
    chk("s2_count", LW'(buf_count), LW'(2));
    chk("s2_first_addr", LW'(wa_q[base]), LW'(16'h1000));
    chk("s2_first_data", wd_q[base], DX);
    @(negedge clk);
    chk("s2_resp_once", LW'(resp_cnt - rc0), LW'(1));
    wait_empty("s2_empty");
    chk("s2_nwrites", LW'(wa_q.size() - base), LW'(3));
    chk("s2_addr1", LW'(wa_q[base+1]), LW'(16'h2000));
    chk("s2_data1", wd_q[base+1], DY);
    chk("s2_addr2", LW'(wa_q[base+2]), LW'(16'h3000));
    chk("s2_data2", wd_q[base+2], DZ);

    // Slow read miss
    mem_lat = 5;
    @(negedge clk);
    rdc0 = rd_cycles;
    l2_req(1'b1, 16'h4440, '0, rdata, lat);
    chk("s3_lat", LW'(lat), LW'(6));
    chk("s3_rdata", rdata, {8{16'h4440}});
    @(negedge clk);
    chk("s3_resp_pulse", LW'(bus.l2_resp), '0);
    chk("s3_rdcyc", LW'(rd_cycles - rdc0), LW'(5));

    // Same-line writes
    mem_lat = 3;
    base = wa_q.size();
    @(negedge clk);
    l2_req(1'b0, 16'h5000, DB, rdata, lat);
    @(negedge clk);
    l2_req(1'b0, 16'h5008, DC, rdata, lat);
`ifdef L2_WB_COALESCE_EN
    chk("s4_count", LW'(buf_count), LW'(1));
`else
    chk("s4_count", LW'(buf_count), LW'(2));
`endif
    @(negedge clk);
    l2_req(1'b1, 16'h5000, '0, rdata, lat);
    chk("s4_rdata", rdata, DC);
    chk("s4_lat", LW'(lat), LW'(1));
    wait_empty("s4_empty");
`ifdef L2_WB_COALESCE_EN
    chk("s4_nwrites", LW'(wa_q.size() - base), LW'(1));
    chk("s4_data0", wd_q[base], DC);
`else
    chk("s4_nwrites", LW'(wa_q.size() - base), LW'(2));
    chk("s4_data0", wd_q[base], DB);
    chk("s4_data1", wd_q[base+1], DC);
`endif
    chk("s4_addr0", LW'(wa_q[base]), LW'(16'h5000));

    // Read arriving during a drain
    mem_lat = 4;
    base = wa_q.size();
    @(negedge clk);
    l2_req(1'b0, 16'h6000, DE, rdata, lat);
    @(negedge clk);
    l2_req(1'b0, 16'h7000, DF, rdata, lat);
    n = 0;
    while (!bus.pmem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("s5_drain_started", LW'(bus.pmem_write), LW'(1));
    rdc0 = rd_cycles;
    l2_req(1'b1, 16'h7000, '0, rdata, lat);
    chk("s5_lat", LW'(lat), LW'(5));
    chk("s5_rdata", rdata, DF);
    chk("s5_count", LW'(buf_count), LW'(1));
    chk("s5_rdcyc", LW'(rd_cycles - rdc0), '0);
    chk("s5_first_addr", LW'(wa_q[base]), LW'(16'h6000));
    wait_empty("s5_empty");
    chk("s5_nwrites", LW'(wa_q.size() - base), LW'(2));
    chk("s5_second_addr", LW'(wa_q[base+1]), LW'(16'h7000));
    chk("s5_second_data", wd_q[base+1], DF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
